set_bit_scanner: RTL and testbench

Streaming successor to the single-shot priority encoder: accepts a WIDTH-bit word and emits every set bit of it, one per beat, in a per-word selectable priority order (LSB-first or MSB-first). Each beat is a one-hot vector with an optional binary index, and the final beat of each word is flagged. Both sides use valid/ready handshakes. The block sits between a request-mask producer and any consumer that must service the set bits sequentially, such as arbiters or interrupt and channel dispatchers.

---
 rtl/set_bit_scanner.sv | 123 ++++++++++++
 tb/tb_set_bit_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/set_bit_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | set_bit_scanner                                                          |
// | Streams every set bit of a word, one one-hot beat per cycle, LSB- or     |
// | MSB-first per word. Define SET_BIT_SCANNER_INDEX_EN to add index_o.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module set_bit_scanner #(
    parameter int WIDTH = 32
`ifdef SET_BIT_SCANNER_INDEX_EN
    ,
    localparam int IDX_W = $clog2(WIDTH)
`endif
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] onehot_o,
`ifdef SET_BIT_SCANNER_INDEX_EN
    output logic [IDX_W-1:0] index_o,
`endif
    output logic             last_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_residual;
    logic [WIDTH-1:0] w_residual_nxt;
    logic             r_dir;
    logic             w_dir_nxt;

    logic [WIDTH-1:0] w_lsb_iso;
    logic [WIDTH-1:0] w_rev_res;
    logic [WIDTH-1:0] w_rev_iso;
    logic [WIDTH-1:0] w_msb_iso;
    logic [WIDTH-1:0] w_pick;
    logic             w_multi;
    logic             w_scan;
    logic             w_out_hs;
    logic             w_accept;

    // Highest set bit is found by isolating the lowest set bit of the mirrored word.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign w_rev_res[gi] = r_residual[WIDTH-1-gi];
            assign w_msb_iso[gi] = w_rev_iso[WIDTH-1-gi];
        end
    endgenerate

    assign w_lsb_iso = r_residual & (~r_residual + c_one);
    assign w_rev_iso = w_rev_res & (~w_rev_res + c_one);
    assign w_pick    = r_dir ? w_msb_iso : w_lsb_iso;
    assign w_multi   = |(r_residual & (r_residual - c_one));

    assign w_scan       = (r_state == ST_SCAN);
    assign data_val_o   = w_scan;
    assign onehot_o     = w_scan ? w_pick : '0;
    assign last_o       = w_scan & ~w_multi;
    assign w_out_hs     = data_val_o & data_ready_i;
    assign data_ready_o = ~srst_i & (~w_scan | (w_out_hs & last_o));
    assign w_accept     = data_val_i & data_ready_o;

`ifdef SET_BIT_SCANNER_INDEX_EN
    logic [IDX_W-1:0] w_index;

    always_comb begin
        w_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_o[i]) begin
                w_index = w_index | IDX_W'(i);
            end
        end
    end

    assign index_o = w_index;
`endif

    // A new accept takes priority: it can only coincide with a last beat.
    always_comb begin
        w_state_nxt    = r_state;
        w_residual_nxt = r_residual;
        w_dir_nxt      = r_dir;
        if (w_accept) begin
            w_state_nxt    = ST_SCAN;
            w_residual_nxt = data_i;
            w_dir_nxt      = dir_i;
        end else if (w_out_hs) begin
            if (last_o) begin
                w_state_nxt    = ST_IDLE;
                w_residual_nxt = '0;
            end else begin
                w_residual_nxt = r_residual & ~onehot_o;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state    <= ST_IDLE;
            r_residual <= '0;
            r_dir      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_residual <= w_residual_nxt;
            r_dir      <= w_dir_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_bit_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_set_bit_scanner                                                       |
// | Directed self-checking bench for set_bit_scanner at WIDTH = 8.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_set_bit_scanner;

    localparam int c_width = 8;

    logic               clk_i;
    logic               srst_i;
    logic [c_width-1:0] data_i;
    logic               dir_i;
    logic               data_val_i;
    logic               data_ready_o;
    logic [c_width-1:0] onehot_o;
`ifdef SET_BIT_SCANNER_INDEX_EN
    logic [2:0]         index_o;
`endif
    logic               last_o;
    logic               data_val_o;
    logic               data_ready_i;

    int n_pass;
    int n_total;

    set_bit_scanner #(
        .WIDTH(c_width)
    ) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .data_i      (data_i),
        .dir_i       (dir_i),
        .data_val_i  (data_val_i),
        .data_ready_o(data_ready_o),
        .onehot_o    (onehot_o),
`ifdef SET_BIT_SCANNER_INDEX_EN
        .index_o     (index_o),
`endif
        .last_o      (last_o),
        .data_val_o  (data_val_o),
        .data_ready_i(data_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input logic val, input logic [7:0] oh,
                            input logic lst, input logic [2:0] idx);
        check({tag, ".val"}, 32'(data_val_o), 32'(val));
        check({tag, ".onehot"}, 32'(onehot_o), 32'(oh));
        check({tag, ".last"}, 32'(last_o), 32'(lst));
`ifdef SET_BIT_SCANNER_INDEX_EN
        check({tag, ".index"}, 32'(index_o), 32'(idx));
`else
        if (idx != idx) $display("unreachable");
`endif
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        srst_i       = 1'b1;
        data_i       = '0;
        dir_i        = 1'b0;
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst.ready", 32'(data_ready_o), 32'd0);
        chk_beat("rst", 1'b0, 8'h00, 1'b0, 3'd0);
        srst_i = 1'b0;
        #1;
        check("rst.ready_after", 32'(data_ready_o), 32'd1);

        // LSB-first A4
        data_i = 8'hA4; dir_i = 1'b0; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_beat("lsb.b0", 1'b1, 8'h04, 1'b0, 3'd2);
        tick();
        chk_beat("lsb.b1", 1'b1, 8'h20, 1'b0, 3'd5);
        tick();
        chk_beat("lsb.b2", 1'b1, 8'h80, 1'b1, 3'd7);
        tick();
        chk_beat("lsb.idle", 1'b0, 8'h00, 1'b0, 3'd0);

        // MSB-first A4
        data_i = 8'hA4; dir_i = 1'b1; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_beat("msb.b0", 1'b1, 8'h80, 1'b0, 3'd7);
        tick();
        chk_beat("msb.b1", 1'b1, 8'h20, 1'b0, 3'd5);
        tick();
        chk_beat("msb.b2", 1'b1, 8'h04, 1'b1, 3'd2);
        tick();
        chk_beat("msb.idle", 1'b0, 8'h00, 1'b0, 3'd0);

        // Zero word
        data_i = 8'h00; dir_i = 1'b0; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_beat("zero.b0", 1'b1, 8'h00, 1'b1, 3'd0);
        tick();
        chk_beat("zero.idle", 1'b0, 8'h00, 1'b0, 3'd0);

        // Backpressure on 81; a competing word must not be taken during the stall
        data_i = 8'h81; dir_i = 1'b0; data_val_i = 1'b1;
        tick();
        data_ready_i = 1'b0;
        data_i = 8'hFF; dir_i = 1'b1;
        #1;
        chk_beat("bp.s0", 1'b1, 8'h01, 1'b0, 3'd0);
        check("bp.s0.ready", 32'(data_ready_o), 32'd0);
        tick();
        chk_beat("bp.s1", 1'b1, 8'h01, 1'b0, 3'd0);
        check("bp.s1.ready", 32'(data_ready_o), 32'd0);
        tick();
        chk_beat("bp.s2", 1'b1, 8'h01, 1'b0, 3'd0);
        check("bp.s2.ready", 32'(data_ready_o), 32'd0);
        data_ready_i = 1'b1;
        data_val_i = 1'b0;
        tick();
        chk_beat("bp.b1", 1'b1, 8'h80, 1'b1, 3'd7);
        tick();
        chk_beat("bp.idle", 1'b0, 8'h00, 1'b0, 3'd0);

        // Back-to-back 03 then 10
        data_i = 8'h03; dir_i = 1'b0; data_val_i = 1'b1;
        tick();
        data_i = 8'h10;
        #1;
        chk_beat("b2b.b0", 1'b1, 8'h01, 1'b0, 3'd0);
        check("b2b.b0.ready", 32'(data_ready_o), 32'd0);
        tick();
        chk_beat("b2b.b1", 1'b1, 8'h02, 1'b1, 3'd1);
        check("b2b.b1.ready", 32'(data_ready_o), 32'd1);
        tick();
        data_val_i = 1'b0;
        chk_beat("b2b.b2", 1'b1, 8'h10, 1'b1, 3'd4);
        tick();
        chk_beat("b2b.idle", 1'b0, 8'h00, 1'b0, 3'd0);

        // Reset mid-scan of FF, then 40
        data_i = 8'hFF; dir_i = 1'b0; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_beat("rms.b0", 1'b1, 8'h01, 1'b0, 3'd0);
        tick();
        chk_beat("rms.b1", 1'b1, 8'h02, 1'b0, 3'd1);
        srst_i = 1'b1;
        #1;
        check("rms.ready_in_rst", 32'(data_ready_o), 32'd0);
        tick();
        chk_beat("rms.after", 1'b0, 8'h00, 1'b0, 3'd0);
        srst_i = 1'b0;
        #1;
        check("rms.ready_out", 32'(data_ready_o), 32'd1);
        data_i = 8'h40; dir_i = 1'b1; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_beat("rms.w2", 1'b1, 8'h40, 1'b1, 3'd6);
        tick();
        chk_beat("rms.idle", 1'b0, 8'h00, 1'b0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
